// File: rtl/pc_sequencer.sv
// PC next-address sequencer: picks the PC source, gates PC loads, holds a redirect
// across instruction-memory stalls, flushes IF/ID and parks the front end on halt.
module pc_sequencer #(
  parameter int WORD_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              ihit,
  input  logic              hazard_stall,
  input  logic              br_taken,
  input  logic [WORD_W-1:0] br_target,
  input  logic              jr_valid,
  input  logic [WORD_W-1:0] jr_target,
  input  logic              jmp_valid,
  input  logic [WORD_W-1:0] jmp_target,
  input  logic              halt,
  output logic [1:0]        pc_select,
  output logic [WORD_W-1:0] jump_data,
  output logic              pc_en,
  output logic              iren,
  output logic              flush,
  output logic              halted,
  output logic              redirect_pending,
  output logic [CNT_W-1:0]  stall_count
);

  typedef enum logic [1:0] {
    FETCH         = 2'd0,
    WAIT_REDIRECT = 2'd1,
    HALTED        = 2'd2
  } state_t;

  localparam logic [1:0] SEL_NEXT   = 2'b00;
  localparam logic [1:0] SEL_BRANCH = 2'b01;
  localparam logic [1:0] SEL_JUMP   = 2'b10;
  localparam logic [1:0] SEL_JR     = 2'b11;

  state_t              r_state;
  logic [1:0]          r_pend_sel;
  logic [WORD_W-1:0]   r_pend_target;
  logic [CNT_W-1:0]    r_stall_count;

  state_t              w_next_state;
  logic                w_redirect;
  logic [1:0]          w_redir_sel;
  logic [WORD_W-1:0]   w_redir_target;
  logic                w_capture;
  logic [1:0]          w_pc_select;
  logic [WORD_W-1:0]   w_jump_data;
  logic                w_pc_en;
  logic                w_iren;
  logic                w_flush;

  // Older instruction wins: EX branch beats ID jr beats ID j/jal.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    w_redir_sel    = SEL_NEXT;
    w_redir_target = '0;
    if (br_taken) begin
      w_redir_sel    = SEL_BRANCH;
      w_redir_target = br_target;
    end else if (jr_valid) begin
      w_redir_sel    = SEL_JR;
      w_redir_target = jr_target;
    end else if (jmp_valid) begin
      w_redir_sel    = SEL_JUMP;
      w_redir_target = jmp_target;
    end
  end

  assign w_redirect = br_taken | jr_valid | jmp_valid;

  always_comb begin
    w_next_state = r_state;
    w_pc_select  = SEL_NEXT;
    w_jump_data  = '0;
    w_pc_en      = 1'b0;
    w_iren       = 1'b0;
    w_flush      = 1'b0;
    w_capture    = 1'b0;
    unique case (r_state)
      FETCH: begin
        w_iren = 1'b1;
        if (halt) begin
          w_flush      = 1'b1;
          w_next_state = HALTED;
        end else if (w_redirect) begin
          w_flush = 1'b1;
          if (ihit) begin
            // Stalled instruction is wrong-path, so hazard_stall does not block the load.
            w_pc_en     = 1'b1;
            w_pc_select = w_redir_sel;
            w_jump_data = w_redir_target;
          end else begin
            w_capture    = 1'b1;
            w_next_state = WAIT_REDIRECT;
          end
        end else begin
          w_pc_en = ihit & ~hazard_stall;
        end
      end
      WAIT_REDIRECT: begin
        w_iren = 1'b1;
        if (ihit) begin
          w_pc_en      = 1'b1;
          w_pc_select  = r_pend_sel;
          w_jump_data  = r_pend_target;
          w_flush      = 1'b1;
          w_next_state = FETCH;
        end
      end
      HALTED: begin
        w_next_state = HALTED;
      end
      default: begin
        w_next_state = FETCH;
      end
    endcase
    if (RST) begin
      w_pc_select = SEL_NEXT;
      w_jump_data = '0;
      w_pc_en     = 1'b0;
      w_iren      = 1'b0;
      w_flush     = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state       <= FETCH;
      r_pend_sel    <= SEL_NEXT;
      r_pend_target <= '0;
      r_stall_count <= '0;
    end else begin
      r_state <= w_next_state;
      if (w_capture) begin
        r_pend_sel    <= w_redir_sel;
        r_pend_target <= w_redir_target;
      end else if (r_state == WAIT_REDIRECT && ihit) begin
        r_pend_sel    <= SEL_NEXT;
        r_pend_target <= '0;
      end
      if (w_iren && !ihit && r_stall_count != {CNT_W{1'b1}}) begin
        r_stall_count <= r_stall_count + CNT_W'(1);
      end
    end
  end

  assign pc_select        = w_pc_select;
  assign jump_data        = w_jump_data;
  assign pc_en            = w_pc_en;
  assign iren             = w_iren;
  assign flush            = w_flush;
  assign halted           = (r_state == HALTED);
  assign redirect_pending = (r_state == WAIT_REDIRECT);
  assign stall_count      = r_stall_count;

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Control block that drives the PC register's next-address selection.
- Each cycle it chooses between sequential fetch, taken branch, immediate jump and register jump, and decides whether the PC advances.
- It holds a redirect that arrives while instruction memory is busy, issues pipeline flushes, and parks the front end after a halt.
- It sits between hazard/branch resolution logic and the PC register, in front of the instruction-memory request path.

Parameters:
- WORD_W, 32, width of addresses and targets.
- CNT_W, 16, width of the saturating fetch-stall counter.

Ports:
- CLK  in  1  system clock
- RST  in  1  synchronous reset, active-high
- ihit  in  1  instruction memory returns the fetch this cycle
- hazard_stall  in  1  decode hazard; hold PC
- br_taken  in  1  EX-stage branch resolved taken
- br_target  in  WORD_W  branch target
- jr_valid  in  1  ID-stage jr
- jr_target  in  WORD_W  register target
- jmp_valid  in  1  ID-stage j/jal
- jmp_target  in  WORD_W  immediate target
- halt  in  1  halt instruction reached commit
- pc_select  out  2  next-PC source: 00 NEXT (PC+4), 01 BRANCH, 10 JUMP, 11 JR
- jump_data  out  WORD_W  target for a non-NEXT select
- pc_en  out  1  PC register loads this cycle
- iren  out  1  instruction fetch request
- flush  out  1  squash IF/ID contents
- halted  out  1  front end halted (sticky)
- redirect_pending  out  1  redirect latched, awaiting ihit
- stall_count  out  CNT_W  fetch-stall cycles

Behaviour:
- Reset: RST sampled on the CLK rising edge. It sets state to FETCH, clears the pending select/target, and clears halted and stall_count.
- While RST is high, outputs are forced to: pc_en=0, iren=0, flush=0, pc_select=00, jump_data=0.
- RST asserted in any state, including WAIT_REDIRECT or HALTED, discards all pending state. No carry-over after release.
- Redirect priority: br_taken > jr_valid > jmp_valid. The older instruction wins; a simultaneous younger redirect is dropped.
- Outputs pc_select, jump_data, pc_en and flush are combinational from state and inputs, with zero-cycle latency. halted, redirect_pending and stall_count are registered.
- States: FETCH, WAIT_REDIRECT, HALTED.
- FETCH, halt=1:
  - Go to HALTED.
  - pc_en=0, flush=1 this cycle.
  - halt overrides every redirect and stall.
- FETCH, redirect present, ihit=1:
  - pc_en=1, pc_select and jump_data from the winning source, flush=1.
  - hazard_stall is ignored because the stalled instruction is wrong-path.
  - Stay in FETCH.
- FETCH, redirect present, ihit=0:
  - Latch select and target.
  - pc_en=0, flush=1.
  - Go to WAIT_REDIRECT; redirect_pending=1 from the next cycle.
- FETCH, no redirect:
  - pc_en = ihit & ~hazard_stall.
  - pc_select=00, jump_data=0, flush=0.
- WAIT_REDIRECT:
  - iren=1.
  - All redirect and halt inputs are ignored, since their sources are flushed.
  - On ihit=1: pc_en=1, pc_select and jump_data from the latched values, flush=1 (the fetched word is wrong-path). Return to FETCH and clear pending.
  - On ihit=0: hold with pc_en=0, flush=0.
- HALTED:
  - iren=0, pc_en=0, flush=0, halted=1.
  - Leaves only via RST.
- iren=1 in FETCH and WAIT_REDIRECT whenever RST=0.
- stall_count:
  - Increments when iren=1 & ihit=0.
  - Saturates at 2^CNT_W-1 with no wrap.
  - Does not count hazard_stall cycles.
  - Frozen in HALTED.
- jump_data is 0 whenever pc_select=00.

Test Plan:
- Reset, then ihit=1 for 4 cycles -> pc_en=1 each cycle, pc_select=00, flush=0, stall_count=0.
- FETCH, ihit=1, br_taken=1, br_target=0x00000040, jmp_valid=1, jmp_target=0x00000100 -> same cycle: pc_select=01, jump_data=0x40, pc_en=1, flush=1.
- FETCH, ihit=0, jr_valid=1, jr_target=0x00000200, then ihit=0 for 2 cycles, then ihit=1:
  - Capture cycle: flush=1, pc_en=0.
  - redirect_pending=1 for the wait cycles.
  - ihit cycle: pc_select=11, jump_data=0x200, pc_en=1, flush=1.
  - stall_count=3.
- In WAIT_REDIRECT, pulse br_taken=1 with target 0x80 -> ignored. The completion cycle still uses the latched 0x200 and select 11.
- ihit=1, hazard_stall=1 for 2 cycles -> pc_en=0, flush=0, stall_count unchanged. Then hazard_stall=1 with jmp_valid=1, jmp_target=0x300 -> pc_en=1, pc_select=10, flush=1.
- halt=1 together with br_taken=1 -> pc_en=0, flush=1, then halted=1, iren=0 indefinitely.
  - ihit and redirects afterward have no effect.
  - RST=1 for one cycle -> halted=0, state FETCH, stall_count=0.
  - RST asserted mid-WAIT_REDIRECT -> redirect_pending=0 next cycle, no pending redirect issued.
